// File: rtl/hyperbus_pkg.sv
// Shared HyperBus target definitions: CA field positions, FSM states, address helper.
package hyperbus_pkg;

  localparam int CA_BYTES  = 6;
  localparam int CA_RW     = 47;
  localparam int CA_AS     = 46;
  localparam int CA_BURST  = 45;
  localparam int CA_ROW_HI = 44;
  localparam int CA_ROW_LO = 16;
  localparam int CA_COL_HI = 2;
  localparam int CA_COL_LO = 0;

  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    WR,
    RD
  } state_e;

  // Byte address of the first transfer: word address {row, col} times two.
  function automatic logic [32:0] ca_byte_addr(input logic [47:0] ca);
    return {ca[CA_ROW_HI:CA_ROW_LO], ca[CA_COL_HI:CA_COL_LO], 1'b0};
  endfunction

endpackage

// File: rtl/hyperbus_target_mem.sv
// Simple dual-port byte RAM: synchronous write, registered read; maps to block RAM.
module hyperbus_target_mem #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value between read strobes.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hyperbus_target.sv
// HyperBus RAM-side responder: oversamples CK/CS#/DQ/RWDS, decodes CA, serves DDR bursts.
module hyperbus_target
  import hyperbus_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int LATENCY_EDGES = 26,
  parameter int MAX_BYTES     = 1280
) (
  input  logic        clock400,
  input  logic        nrst,
  input  logic        ram_ck,
  input  logic        ram_cs_n,
  input  logic [7:0]  dq_in,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  input  logic        rwds_in,
  output logic        rwds_out,
  output logic        rwds_oe,
  output logic        busy,
  output logic [47:0] last_ca,
  output logic [15:0] txn_count,
  output logic        err_abort,
  output logic        err_overrun
);

  // Pin sample order {ck, cs_n, rwds, dq}; CS# resets inactive (high).
  localparam logic [10:0] PINS_RST = 11'b010_0000_0000;

  logic [10:0] pins_d, sync1_q, sync2_q;
  logic        ck_s, cs_s, rwds_s;
  logic [7:0]  dq_s;
  logic        ck_prev_q, cs_prev_q;
  logic        ck_edge, cs_fall;

  state_e              state_q, state_d;
  logic [47:0]         ca_q, ca_d, last_ca_q, last_ca_d, ca_next;
  logic [7:0]          edge_cnt_q, edge_cnt_d;
  logic [15:0]         byte_cnt_q, byte_cnt_d, txn_q, txn_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, mem_raddr;
  logic [7:0]          dq_out_q, dq_out_d, mem_rdata;
  logic                dq_oe_q, dq_oe_d, rwds_out_q, rwds_out_d, rwds_oe_q, rwds_oe_d;
  logic                busy_q, busy_d, err_abort_q, err_abort_d, err_ovr_q, err_ovr_d;
  logic                mem_we, mem_re, data_edge, is_rd, overrun;

  assign pins_d = {ram_ck, ram_cs_n, rwds_in, dq_in};
  assign {ck_s, cs_s, rwds_s, dq_s} = sync2_q;
  assign ck_edge = ck_s ^ ck_prev_q;
  assign cs_fall = cs_prev_q & ~cs_s;
  assign ca_next = {ca_q[39:0], dq_s};

  // Two-flop synchronizer for all host pins plus previous-sample flops for edge detect.
  always_ff @(posedge clock400 or negedge nrst) begin
    if (!nrst) begin
      sync1_q   <= PINS_RST;
      sync2_q   <= PINS_RST;
      ck_prev_q <= 1'b0;
      cs_prev_q <= 1'b1;
    end else begin
      sync1_q   <= pins_d;
      sync2_q   <= sync1_q;
      ck_prev_q <= ck_s;
      cs_prev_q <= cs_s;
    end
  end

  // Next-state logic. The LATENCY_EDGES-th edge after CA is itself the first data edge.
  always_comb begin
    state_d     = state_q;
    ca_d        = ca_q;
    last_ca_d   = last_ca_q;
    edge_cnt_d  = edge_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    rwds_out_d  = rwds_out_q;
    rwds_oe_d   = rwds_oe_q;
    txn_d       = txn_q;
    err_abort_d = err_abort_q;
    err_ovr_d   = err_ovr_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_raddr   = addr_q;
    data_edge   = 1'b0;
    is_rd       = ca_q[CA_RW];
    overrun     = byte_cnt_q >= 16'(MAX_BYTES);
    if (cs_s) begin
      // CS# high ends any transaction; edges are ignored.
      if (state_q != IDLE) begin
        state_d    = IDLE;
        dq_oe_d    = 1'b0;
        rwds_oe_d  = 1'b0;
        dq_out_d   = 8'h00;
        rwds_out_d = 1'b0;
        if (state_q == CA || state_q == LAT) err_abort_d = 1'b1;
        else                                 txn_d       = txn_q + 16'd1;
      end
    end else begin
      case (state_q)
        IDLE: if (cs_fall) begin
          edge_cnt_d = '0;
          byte_cnt_d = '0;
          rwds_oe_d  = 1'b1;    // fixed 1x latency indication
          rwds_out_d = 1'b0;
          state_d    = CA;
        end
        CA: if (ck_edge) begin
          ca_d       = ca_next;
          edge_cnt_d = edge_cnt_q + 8'd1;
          if (edge_cnt_q == 8'(CA_BYTES - 1)) begin
            last_ca_d  = ca_next;
            addr_d     = ADDR_W'(ca_byte_addr(ca_next));
            rwds_oe_d  = 1'b0;
            edge_cnt_d = '0;
            state_d    = LAT;
          end
        end
        LAT: if (ck_edge) begin
          edge_cnt_d = edge_cnt_q + 8'd1;
          if (edge_cnt_q == 8'(LATENCY_EDGES - 2) && is_rd) mem_re = 1'b1;  // prefetch first byte
          if (edge_cnt_q == 8'(LATENCY_EDGES - 1)) begin
            data_edge = 1'b1;
            state_d   = is_rd ? RD : WR;
          end
        end
        WR, RD: data_edge = ck_edge;
        default: ;
      endcase
      if (data_edge) begin
        addr_d = addr_q + ADDR_W'(1);
        if (overrun) err_ovr_d  = 1'b1;
        else         byte_cnt_d = byte_cnt_q + 16'd1;
        if (is_rd) begin
          dq_oe_d    = 1'b1;
          rwds_oe_d  = 1'b1;
          rwds_out_d = (state_q == LAT) ? 1'b1 : ~rwds_out_q;
          dq_out_d   = overrun ? 8'h00 : mem_rdata;
          mem_re     = 1'b1;    // next byte ready well before the next edge
          mem_raddr  = addr_q + ADDR_W'(1);
        end else begin
          mem_we = ~rwds_s & ~overrun;
        end
      end
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock400 or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      ca_q        <= '0;
      last_ca_q   <= '0;
      edge_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      rwds_out_q  <= 1'b0;
      rwds_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      txn_q       <= '0;
      err_abort_q <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ca_q        <= ca_d;
      last_ca_q   <= last_ca_d;
      edge_cnt_q  <= edge_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      rwds_out_q  <= rwds_out_d;
      rwds_oe_q   <= rwds_oe_d;
      busy_q      <= busy_d;
      txn_q       <= txn_d;
      err_abort_q <= err_abort_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  hyperbus_target_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clock400),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (dq_s),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Drivers drop in the very cycle the synchronized CS# is high.
  assign dq_oe       = dq_oe_q & ~cs_s;
  assign rwds_oe     = rwds_oe_q & ~cs_s;
  assign dq_out      = dq_out_q;
  assign rwds_out    = rwds_out_q;
  assign busy        = busy_q;
  assign last_ca     = last_ca_q;
  assign txn_count   = txn_q;
  assign err_abort   = err_abort_q;
  assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_hyperbus_target.sv
// Scoreboard bench for hyperbus_target: host-side CK/CS#/DQ driver and byte memory model.
module tb_hyperbus_target;

  localparam int AW   = 4;
  localparam int MSZ  = 16;
  localparam int LAT  = 26;
  localparam int MAXB = 12;

  logic        clock400 = 1'b0;
  logic        nrst     = 1'b0;
  logic        ram_ck   = 1'b0;
  logic        ram_cs_n = 1'b1;
  logic [7:0]  dq_in    = 8'h00;
  logic        rwds_in  = 1'b0;
  logic [7:0]  dq_out;
  logic        dq_oe, rwds_out, rwds_oe, busy, err_abort, err_overrun;
  logic [47:0] last_ca;
  logic [15:0] txn_count;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_txn = 0;
  logic [7:0]  model [MSZ];
  logic [7:0]  wd [MSZ];
  logic        wm [MSZ];
  logic [7:0]  sb [$];

  hyperbus_target #(.ADDR_W(AW), .LATENCY_EDGES(LAT), .MAX_BYTES(MAXB)) dut (
    .clock400(clock400), .nrst(nrst), .ram_ck(ram_ck), .ram_cs_n(ram_cs_n),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .rwds_in(rwds_in),
    .rwds_out(rwds_out), .rwds_oe(rwds_oe), .busy(busy), .last_ca(last_ca),
    .txn_count(txn_count), .err_abort(err_abort), .err_overrun(err_overrun)
  );

  always #5 clock400 = ~clock400;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required summary before 1ms");
    $fatal(1);
  end

  function automatic logic [47:0] ca_of(input logic rd, input int word);
    logic [47:0] c = '0;
    c[47]    = rd;
    c[44:16] = 29'(word >> 3);
    c[2:0]   = 3'(word);
    return c;
  endfunction

  // One CK edge: data set up 2 cycles before the toggle, level held 5 cycles.
  task automatic tick(input logic [7:0] d, input logic m);
    dq_in = d; rwds_in = m;
    repeat (2) @(negedge clock400);
    ram_ck = ~ram_ck;
    repeat (3) @(negedge clock400);
  endtask

  // CS# low, six CA bytes, then the LAT-1 idle latency edges.
  task automatic start_txn(input logic [47:0] ca);
    ram_cs_n = 1'b0;
    repeat (4) @(negedge clock400);
    for (int i = 0; i < 6; i++) tick(ca[47-8*i -: 8], 1'b0);
    for (int i = 0; i < LAT - 1; i++) tick(8'h00, 1'b0);
  endtask

  task automatic end_txn();
    ram_cs_n = 1'b1;
    repeat (4) @(negedge clock400);
  endtask

  task automatic do_write(input int word, input int n);
    start_txn(ca_of(1'b0, word));
    for (int i = 0; i < n; i++) begin
      tick(wd[i], wm[i]);
      if (!wm[i] && i < MAXB) model[(word * 2 + i) % MSZ] = wd[i];
    end
    end_txn();
    exp_txn++;
  endtask

  // Read burst: expected bytes queued from the model, popped per data edge.
  task automatic do_read(input int word, input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) sb.push_back(i < MAXB ? model[(word * 2 + i) % MSZ] : 8'h00);
    start_txn(ca_of(1'b1, word));
    n_vec++;
    if (dq_oe !== 1'b0) begin n_err++; $display("FAIL rd_lat_oe: dq_oe=%b want 0", dq_oe); end
    for (int i = 0; i < n; i++) begin
      tick(8'h00, 1'b0);
      e = sb.pop_front();
      n_vec++;
      if (dq_out !== e || rwds_out !== ~i[0] || dq_oe !== 1'b1 || rwds_oe !== 1'b1) begin
        n_err++;
        $display("FAIL rd_data[%0d] word %0d: dq=%h rwds=%b oe=%b/%b want dq=%h rwds=%b oe=1/1",
                 i, word, dq_out, rwds_out, dq_oe, rwds_oe, e, ~i[0]);
      end
    end
    end_txn();
    exp_txn++;
    n_vec++;
    if (dq_oe !== 1'b0 || rwds_oe !== 1'b0 || busy !== 1'b0 || txn_count !== 16'(exp_txn)) begin
      n_err++;
      $display("FAIL rd_end: oe=%b/%b busy=%b txn=%0d want 0/0 0 %0d", dq_oe, rwds_oe, busy, txn_count, exp_txn);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock400);
    n_vec++;
    if ({dq_out, dq_oe, rwds_out, rwds_oe, busy, last_ca, txn_count, err_abort, err_overrun} !== '0) begin
      n_err++; $display("FAIL reset_outputs: oe=%b busy=%b txn=%0d last_ca=%h want all 0", dq_oe, busy, txn_count, last_ca);
    end
    nrst = 1'b1;
    repeat (3) @(negedge clock400);
    n_vec++;
    if (busy !== 1'b0 || dq_oe !== 1'b0 || rwds_oe !== 1'b0) begin
      n_err++; $display("FAIL reset_release: busy=%b oe=%b/%b want 0", busy, dq_oe, rwds_oe);
    end
  endtask

  task automatic test_write();
    for (int i = 0; i < 8; i++) begin wd[i] = 8'((i + 1) * 8'h11); wm[i] = 1'b0; end
    ram_cs_n = 1'b0;
    repeat (4) @(negedge clock400);
    n_vec++;
    if (rwds_oe !== 1'b1 || rwds_out !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL ca_rwds: rwds_oe=%b rwds=%b busy=%b want 1 0 1", rwds_oe, rwds_out, busy);
    end
    for (int i = 0; i < 6; i++) tick(8'h00, 1'b0);
    for (int i = 0; i < LAT - 1; i++) tick(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(wd[i], 1'b0);
      model[i] = wd[i];
      n_vec++;
      if (dq_oe !== 1'b0 || rwds_oe !== 1'b0) begin
        n_err++; $display("FAIL wr_oe[%0d]: oe=%b/%b want 0/0", i, dq_oe, rwds_oe);
      end
    end
    end_txn();
    exp_txn++;
    n_vec++;
    if (txn_count !== 16'(exp_txn) || busy !== 1'b0 || err_abort !== 1'b0) begin
      n_err++; $display("FAIL wr_end: txn=%0d busy=%b abort=%b want %0d 0 0", txn_count, busy, err_abort, exp_txn);
    end
  endtask

  task automatic test_read();
    do_read(0, 8);
    n_vec++;
    if (last_ca !== 48'h8000_0000_0000) begin
      n_err++; $display("FAIL rd_last_ca: %h want 800000000000", last_ca);
    end
  endtask

  task automatic test_masked();
    for (int i = 0; i < 4; i++) begin wd[i] = 8'hAA; wm[i] = i[0]; end
    do_write(0, 4);
    do_read(0, 4);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin wd[i] = 8'(8'hC1 + i); wm[i] = 1'b0; end
    do_write(7, 4);
    n_vec++;
    if (last_ca !== 48'h0000_0000_0007) begin
      n_err++; $display("FAIL wrap_last_ca: %h want 000000000007", last_ca);
    end
    do_read(7, 4);
    do_read(0, 4);
  endtask

  task automatic test_abort();
    ram_cs_n = 1'b0;
    repeat (4) @(negedge clock400);
    for (int i = 0; i < 3; i++) tick(8'h80, 1'b0);
    n_vec++;
    if (rwds_oe !== 1'b1) begin n_err++; $display("FAIL abort_pre: rwds_oe=%b want 1", rwds_oe); end
    ram_cs_n = 1'b1;
    repeat (3) @(negedge clock400);
    n_vec++;
    if (dq_oe !== 1'b0 || rwds_oe !== 1'b0) begin
      n_err++; $display("FAIL abort_release: oe=%b/%b want 0/0", dq_oe, rwds_oe);
    end
    repeat (2) @(negedge clock400);
    n_vec++;
    if (err_abort !== 1'b1 || txn_count !== 16'(exp_txn) || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_flags: abort=%b txn=%0d busy=%b want 1 %0d 0", err_abort, txn_count, busy, exp_txn);
    end
    do_read(0, 4);
  endtask

  task automatic test_overrun();
    n_vec++;
    if (err_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_pre: err_overrun=%b want 0", err_overrun); end
    for (int i = 0; i < 4; i++) begin wd[i] = 8'(8'hE0 + i); wm[i] = 1'b0; end
    do_write(6, 4);
    for (int i = 0; i < 14; i++) begin wd[i] = 8'(8'h30 + i); wm[i] = 1'b0; end
    do_write(0, 14);
    n_vec++;
    if (err_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: err_overrun=%b want 1", err_overrun); end
    do_read(0, 14);
    do_read(6, 2);
  endtask

  task automatic test_reset_mid_read();
    start_txn(ca_of(1'b1, 0));
    for (int i = 0; i < 3; i++) tick(8'h00, 1'b0);
    n_vec++;
    if (dq_oe !== 1'b1) begin n_err++; $display("FAIL mid_rd_oe: dq_oe=%b want 1", dq_oe); end
    nrst = 1'b0;
    #1;
    n_vec++;
    if (dq_oe !== 1'b0 || rwds_oe !== 1'b0 || busy !== 1'b0 || txn_count !== 16'd0) begin
      n_err++; $display("FAIL mid_rd_reset: oe=%b/%b busy=%b txn=%0d want 0/0 0 0", dq_oe, rwds_oe, busy, txn_count);
    end
    ram_cs_n = 1'b1;
    repeat (3) @(negedge clock400);
    nrst = 1'b1;
    repeat (4) @(negedge clock400);
    exp_txn = 0;
    n_vec++;
    if (busy !== 1'b0 || err_abort !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: busy=%b abort=%b want 0 0", busy, err_abort);
    end
    do_read(0, 4);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_masked();
    test_wrap();
    test_abort();
    test_overrun();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hyperbus_target.md
Name: hyperbus_target

Overview:
- Synthesizable HyperBus target (RAM-side responder) for FPGA loopback and bring-up of the HyperRAM controller.
- Samples host CK/CS#/DQ/RWDS with a single fast clock and decodes the 48-bit command/address (CA).
- Counts a fixed latency, then serves DDR reads from, or captures DDR writes into, an internal byte memory.
- Sits opposite the controller on the board, or in a second FPGA, with the real HyperRAM removed.

Parameters:
- ADDR_W, 12: byte-address width of the internal memory (2**ADDR_W bytes).
- LATENCY_EDGES, 26: CK edges (rise and fall) between the last CA byte and the first data byte.
- MAX_BYTES, 1280: bytes per transaction; bytes beyond this are ignored or driven as 0x00 and counted as overrun.

Ports:
- clock400  in  1  sampling clock; each CK level must be stable for at least 2 clock400 cycles.
- nrst  in  1  asynchronous, active-low reset.
- ram_ck  in  1  host CK, treated as data and sampled.
- ram_cs_n  in  1  host chip select, active low.
- dq_in  in  8  DQ bus as seen at the pad.
- dq_out  out  8  DQ drive value.
- dq_oe  out  1  DQ output enable.
- rwds_in  in  1  RWDS from host; write byte mask, high = masked.
- rwds_out  out  1  RWDS drive value.
- rwds_oe  out  1  RWDS output enable.
- busy  out  1  high while a transaction is active.
- last_ca  out  48  CA of the most recent transaction.
- txn_count  out  16  completed transactions, wrapping.
- err_abort  out  1  sticky: CS# rose before the data phase.
- err_overrun  out  1  sticky: more than MAX_BYTES bytes were transferred.

Behaviour:
- Input sampling:
  - ram_ck, ram_cs_n, dq_in and rwds_in pass through a 2-flop synchronizer into clock400.
  - edge = sampled CK differs from its previous sample. Both rise and fall are data edges.
- Reset:
  - All outputs are 0; state = IDLE; memory contents are undefined.
  - Asynchronous assertion; release is synchronized by the internal pipeline only.
- States and transitions:
  - IDLE: on CS# falling, clear edge_cnt and byte_cnt, drive rwds_oe=1 with rwds_out=0 (fixed 1x latency), go to CA.
  - CA: on each edge, shift dq_in into ca_sr. On the 6th edge, latch last_ca, release rwds_oe, compute the start byte address, go to LAT.
  - LAT: count edges. At edge LATENCY_EDGES-1, issue the prefetch read when CA[47]=1. At edge LATENCY_EDGES, go to RD if CA[47]=1, otherwise WR.
  - WR: on each edge, write dq_in to mem[addr] unless rwds_in=1, then addr++ and byte_cnt++. dq_oe=0 and rwds_oe=0 throughout.
  - RD: dq_oe=1, rwds_oe=1. On each edge, drive the prefetched byte and toggle rwds_out (first data edge drives rwds_out=1). Issue the read for addr+1 in the same cycle so data is registered before the next edge.
- Address arithmetic:
  - Start byte address = {CA[44:16], CA[2:0]} << 1, truncated to ADDR_W bits.
  - Increment wraps modulo 2**ADDR_W. Burst type CA[45] is ignored; bursts are always linear.
- CS# rising, from any state:
  - Outputs are released (dq_oe=0, rwds_oe=0) on the same cycle the synchronized CS# is seen high.
  - State returns to IDLE.
  - From CA or LAT: set err_abort; txn_count unchanged.
  - From RD or WR: txn_count++ and busy falls one cycle later.
- Overrun: when byte_cnt reaches MAX_BYTES, further writes are dropped and reads drive 0x00; err_overrun is set.
- Edges seen while CS# is high are ignored.
- A new CS# fall in the same cycle as the IDLE entry is taken on the next cycle.
- Latency from a CK edge to a new dq_out/rwds_out value: 1 clock400 cycle (registered outputs). The host samples on the following half period.

Decomposition:
- Package hyperbus_pkg holds:
  - The CA field constants: RW bit 47, AS bit 46, BURST bit 45, row range [44:16], column range [2:0].
  - The state enum: IDLE, CA, LAT, WR, RD.
  - CA_BYTES = 6.
- Sub-module hyperbus_target_mem: a simple dual-port byte RAM, 2**ADDR_W x 8, with a synchronous write port and a registered read port. It infers block RAM.

Test Plan:
- Write burst: CA 0x000000000000 (write, address 0), 8 bytes 0x11..0x88 with RWDS=0, then CS# high → mem[0..7] = 0x11..0x88, txn_count=1.
- Read back: CA 0x800000000000, 8 bytes read → dq_out sequence 0x11..0x88 from edge 26 after CA, rwds toggling 1,0,1,…, and dq_oe=1 only in RD.
- Masked write: write 4 bytes 0xAA to address 0 with RWDS=1 on bytes 1 and 3, then read → 0xAA,0x22,0xAA,0x44.
- Wrap: ADDR_W=4, write 4 bytes starting at word address 7 (byte 14) → bytes land at 14, 15, 0, 1.
- Abort: CS# rises after the 3rd CA byte → err_abort=1, txn_count unchanged, dq_oe=rwds_oe=0 within 3 clock400 cycles, and the next full transaction succeeds.
- Reset mid-read: assert nrst low during RD → dq_oe, rwds_oe and busy are 0 immediately; after release the state is IDLE and a new read returns the correct data.
